// File: rtl/mac_pkg.sv
// Shared definitions for the MAC error-statistics block: default widths and
// the measurement FSM state encoding.
package mac_pkg;

  localparam int unsigned DEF_RES_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH = 16;
  localparam int unsigned DEF_SUM_WIDTH = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_err_stats_if.sv
// Bundle of run control, sample inputs and statistics outputs between the
// result source (master) and the statistics block (slave).
interface mac_err_stats_if
  import mac_pkg::*;
#(
  parameter int unsigned RES_WIDTH = DEF_RES_WIDTH,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned SUM_WIDTH = DEF_SUM_WIDTH
);

  logic                 start;
  logic [CNT_WIDTH-1:0] n_samples;
  logic                 valid_in;
  logic [RES_WIDTH-1:0] r_exact;
  logic [RES_WIDTH-1:0] r_approx;

  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] sample_cnt;
  logic [CNT_WIDTH-1:0] err_count;
  logic [RES_WIDTH-1:0] max_err;
  logic [SUM_WIDTH-1:0] sum_err;
  logic                 sum_sat;

  modport master (
    output start, n_samples, valid_in, r_exact, r_approx,
    input  busy, done, sample_cnt, err_count, max_err, sum_err, sum_sat
  );

  modport slave (
    input  start, n_samples, valid_in, r_exact, r_approx,
    output busy, done, sample_cnt, err_count, max_err, sum_err, sum_sat
  );

endinterface

// File: rtl/mac_err_stats_abs_diff.sv
// Combinational absolute difference and mismatch flag of two unsigned MAC
// results; the parent registers the outputs as pipeline stage 1.
module abs_diff
  import mac_pkg::*;
#(
  parameter int unsigned RES_WIDTH = DEF_RES_WIDTH
) (
  input  logic [RES_WIDTH-1:0] a,
  input  logic [RES_WIDTH-1:0] b,
  output logic [RES_WIDTH-1:0] diff,
  output logic                 mismatch
);

  // Subtract the smaller from the larger so the result never wraps.
  always_comb begin
    if (a >= b) begin
      diff = a - b;
    end else begin
      diff = b - a;
    end
    mismatch = (a != b);
  end

endmodule

// File: rtl/mac_err_stats.sv
// Error statistics between the exact and approximate results of two MAC
// instances fed the same operands. A run of n_samples accepted samples goes
// through a two-stage pipeline (abs diff, then accumulate) and ends with a
// one-cycle done pulse. SUM_WIDTH must be at least RES_WIDTH.
module mac_err_stats
  import mac_pkg::*;
#(
  parameter int unsigned RES_WIDTH = DEF_RES_WIDTH,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned SUM_WIDTH = DEF_SUM_WIDTH
) (
  input logic            clk,
  input logic            rst,
  mac_err_stats_if.slave bus
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] n_lat_q, n_lat_d;
  logic [CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [RES_WIDTH-1:0] max_err_q, max_err_d;
  logic [SUM_WIDTH-1:0] sum_err_q, sum_err_d;
  logic                 sum_sat_q, sum_sat_d;

  // Pipeline stage 1: registered difference of the accepted sample.
  logic                 s1_vld_q, s1_vld_d;
  logic [RES_WIDTH-1:0] s1_diff_q, s1_diff_d;
  logic                 s1_mis_q, s1_mis_d;

  logic [RES_WIDTH-1:0] diff_w;
  logic                 mis_w;
  logic                 start_ok;
  logic                 accept;
  logic                 last_accept;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [SUM_WIDTH:0]   sum_ext;

  abs_diff #(
    .RES_WIDTH (RES_WIDTH)
  ) u_abs_diff (
    .a        (bus.r_exact),
    .b        (bus.r_approx),
    .diff     (diff_w),
    .mismatch (mis_w)
  );

  assign start_ok    = (state_q == ST_IDLE) && bus.start;
  assign accept      = (state_q == ST_RUN) && bus.valid_in;
  assign cnt_inc     = sample_cnt_q + CNT_WIDTH'(1);
  assign last_accept = accept && (cnt_inc == n_lat_q);
  // One extra bit catches the carry that signals saturation.
  assign sum_ext     = {1'b0, sum_err_q} + (SUM_WIDTH + 1)'(s1_diff_q);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch
    // is inferred when a case arm leaves the state unchanged.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.n_samples != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (last_accept) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and statistics onto the bus.
  always_comb begin
    bus.busy       = (state_q != ST_IDLE);
    bus.done       = (state_q == ST_DONE);
    bus.sample_cnt = sample_cnt_q;
    bus.err_count  = err_count_q;
    bus.max_err    = max_err_q;
    bus.sum_err    = sum_err_q;
    bus.sum_sat    = sum_sat_q;
  end

  // Datapath: stage-1 capture, stage-2 accumulation, clear on accepted start.
  always_comb begin
    n_lat_d      = n_lat_q;
    sample_cnt_d = sample_cnt_q;
    err_count_d  = err_count_q;
    max_err_d    = max_err_q;
    sum_err_d    = sum_err_q;
    sum_sat_d    = sum_sat_q;
    s1_vld_d     = accept;
    s1_diff_d    = s1_diff_q;
    s1_mis_d     = s1_mis_q;

    if (accept) begin
      s1_diff_d    = diff_w;
      s1_mis_d     = mis_w;
      sample_cnt_d = cnt_inc;
    end

    if (s1_vld_q) begin
      if (sum_ext[SUM_WIDTH]) begin
        sum_err_d = '1;
        sum_sat_d = 1'b1;
      end else begin
        sum_err_d = sum_ext[SUM_WIDTH-1:0];
      end
      if (s1_diff_q > max_err_q) begin
        max_err_d = s1_diff_q;
      end
      if (s1_mis_q) begin
        err_count_d = err_count_q + CNT_WIDTH'(1);
      end
    end

    // A start can only be accepted in IDLE, where stage 1 is always empty.
    if (start_ok) begin
      n_lat_d      = bus.n_samples;
      sample_cnt_d = '0;
      err_count_d  = '0;
      max_err_d    = '0;
      sum_err_d    = '0;
      sum_sat_d    = 1'b0;
      s1_vld_d     = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: pipeline data registers are reset too, so a run aborted by reset
    // leaves no stale difference that could leak into the next run.
    if (rst) begin
      n_lat_q      <= '0;
      sample_cnt_q <= '0;
      err_count_q  <= '0;
      max_err_q    <= '0;
      sum_err_q    <= '0;
      sum_sat_q    <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_diff_q    <= '0;
      s1_mis_q     <= 1'b0;
    end else begin
      n_lat_q      <= n_lat_d;
      sample_cnt_q <= sample_cnt_d;
      err_count_q  <= err_count_d;
      max_err_q    <= max_err_d;
      sum_err_q    <= sum_err_d;
      sum_sat_q    <= sum_sat_d;
      s1_vld_q     <= s1_vld_d;
      s1_diff_q    <= s1_diff_d;
      s1_mis_q     <= s1_mis_d;
    end
  end

endmodule

// File: tb/tb_mac_err_stats.sv
// Bench for mac_err_stats: two instances (48-bit and 33-bit sum) share one
// stimulus stream; expected statistics come from a queue-based model.
module tb_mac_err_stats;
  import mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] n_samples;
  logic        valid_in;
  logic [31:0] r_exact;
  logic [31:0] r_approx;

  always #5 clk = ~clk;

  mac_err_stats_if #(.RES_WIDTH(32), .CNT_WIDTH(16), .SUM_WIDTH(48)) bus48 ();
  mac_err_stats_if #(.RES_WIDTH(32), .CNT_WIDTH(16), .SUM_WIDTH(33)) bus33 ();

  assign bus48.start     = start;
  assign bus48.n_samples = n_samples;
  assign bus48.valid_in  = valid_in;
  assign bus48.r_exact   = r_exact;
  assign bus48.r_approx  = r_approx;
  assign bus33.start     = start;
  assign bus33.n_samples = n_samples;
  assign bus33.valid_in  = valid_in;
  assign bus33.r_exact   = r_exact;
  assign bus33.r_approx  = r_approx;

  mac_err_stats #(.RES_WIDTH(32), .CNT_WIDTH(16), .SUM_WIDTH(48)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus48)
  );

  mac_err_stats #(.RES_WIDTH(32), .CNT_WIDTH(16), .SUM_WIDTH(33)) dut33 (
    .clk (clk),
    .rst (rst),
    .bus (bus33)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus for the next run and the samples actually accepted so far.
  logic [31:0] st_ex[$];
  logic [31:0] st_ap[$];
  logic [31:0] q_ex[$];
  logic [31:0] q_ap[$];

  // Model results.
  logic [63:0] m_cnt, m_err, m_max, m_sum48, m_sum33;
  logic        m_sat48, m_sat33;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Statistics straight from the definitions: count, mismatches, largest
  // absolute difference, and a sum clamped at 2^w-1 with a sticky flag.
  function automatic void compute_model();
    logic [63:0] d;
    logic [63:0] lim48 = (64'd1 << 48) - 64'd1;
    logic [63:0] lim33 = (64'd1 << 33) - 64'd1;
    m_cnt = 0; m_err = 0; m_max = 0; m_sum48 = 0; m_sum33 = 0;
    m_sat48 = 1'b0; m_sat33 = 1'b0;
    foreach (q_ex[i]) begin
      d = (q_ex[i] >= q_ap[i]) ? 64'(q_ex[i]) - 64'(q_ap[i]) : 64'(q_ap[i]) - 64'(q_ex[i]);
      m_cnt++;
      if (q_ex[i] != q_ap[i]) m_err++;
      if (d > m_max) m_max = d;
      m_sum48 = m_sum48 + d;
      if (m_sum48 > lim48) begin m_sum48 = lim48; m_sat48 = 1'b1; end
      m_sum33 = m_sum33 + d;
      if (m_sum33 > lim33) begin m_sum33 = lim33; m_sat33 = 1'b1; end
    end
  endfunction

  task automatic check_stats(input string tag);
    compute_model();
    check({tag, ".cnt"},     64'(bus48.sample_cnt), m_cnt);
    check({tag, ".err"},     64'(bus48.err_count),  m_err);
    check({tag, ".max"},     64'(bus48.max_err),    m_max);
    check({tag, ".sum48"},   64'(bus48.sum_err),    m_sum48);
    check({tag, ".sat48"},   64'(bus48.sum_sat),    64'(m_sat48));
    check({tag, ".cnt33"},   64'(bus33.sample_cnt), m_cnt);
    check({tag, ".sum33"},   64'(bus33.sum_err),    m_sum33);
    check({tag, ".sat33"},   64'(bus33.sum_sat),    64'(m_sat33));
  endtask

  task automatic check_ctrl(input string tag, input logic busy_e, input logic done_e);
    check({tag, ".busy"},   64'(bus48.busy), 64'(busy_e));
    check({tag, ".done"},   64'(bus48.done), 64'(done_e));
    check({tag, ".done33"}, 64'(bus33.done), 64'(done_e));
  endtask

  task automatic add_pair(input logic [31:0] e, input logic [31:0] a);
    st_ex.push_back(e);
    st_ap.push_back(a);
  endtask

  task automatic add_rand();
    logic [31:0] e;
    logic [31:0] a;
    e = $urandom();
    case ($urandom_range(0, 3))
      0:       a = e;
      1:       a = e + 32'($urandom_range(0, 15));
      2:       a = e - 32'($urandom_range(0, 15));
      default: a = $urandom();
    endcase
    add_pair(e, a);
  endtask

  // One full run from IDLE using st_ex/st_ap; random gaps of up to max_gap
  // idle cycles, optionally with start pulses while the run is in progress.
  task automatic run(input string tag, input int max_gap, input bit poke);
    int n;
    n = st_ex.size();
    q_ex.delete();
    q_ap.delete();
    start     = 1'b1;
    n_samples = 16'(n);
    valid_in  = 1'b1;
    r_exact   = $urandom();
    r_approx  = $urandom();
    tick();
    start    = 1'b0;
    valid_in = 1'b0;
    if (n == 0) begin
      check_ctrl({tag, ".zero_done"}, 1'b1, 1'b1);
      check_stats({tag, ".zero"});
      tick();
      check_ctrl({tag, ".zero_idle"}, 1'b0, 1'b0);
    end else begin
      check_ctrl({tag, ".run"}, 1'b1, 1'b0);
      check_stats({tag, ".clr"});
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, max_gap)) begin
          valid_in  = 1'b0;
          r_exact   = $urandom();
          r_approx  = $urandom();
          start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
          n_samples = 16'($urandom_range(0, 3));
          tick();
          check({tag, ".gap_cnt"}, 64'(bus48.sample_cnt), 64'(i));
        end
        start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        valid_in = 1'b1;
        r_exact  = st_ex[i];
        r_approx = st_ap[i];
        tick();
        q_ex.push_back(st_ex[i]);
        q_ap.push_back(st_ap[i]);
        check({tag, ".acc_cnt"}, 64'(bus48.sample_cnt), 64'(i + 1));
      end
      // Inputs during DRAIN and DONE must be ignored.
      valid_in = 1'b1;
      start    = poke;
      r_exact  = $urandom();
      r_approx = 32'h0;
      check_ctrl({tag, ".drain"}, 1'b1, 1'b0);
      tick();
      check_ctrl({tag, ".done"}, 1'b1, 1'b1);
      check_stats({tag, ".final"});
      start = 1'b0;
      tick();
      check_ctrl({tag, ".after"}, 1'b0, 1'b0);
      tick();
      valid_in = 1'b0;
      check_stats({tag, ".hold"});
    end
    st_ex.delete();
    st_ap.delete();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    n_samples = '0;
    valid_in  = 1'b0;
    r_exact   = '0;
    r_approx  = '0;
    q_ex.delete();
    q_ap.delete();
    tick();
    tick();
    check_ctrl("reset", 1'b0, 1'b0);
    check_stats("reset");
    rst = 1'b0;
    tick();

    // Four identical pairs back-to-back.
    repeat (4) add_pair(32'd100, 32'd100);
    run("equal4", 0, 1'b0);

    // Mixed mismatches: diffs 3, 4, 0.
    add_pair(32'd10, 32'd7);
    add_pair(32'd5,  32'd9);
    add_pair(32'd0,  32'd0);
    run("mixed3", 0, 1'b0);

    // Largest possible difference.
    add_pair(32'h0, 32'hFFFF_FFFF);
    run("maxdiff", 0, 1'b0);

    // Empty run, then a run with start pulses during RUN.
    run("empty", 0, 1'b0);
    repeat (5) add_rand();
    run("poke", 2, 1'b1);

    // Reset after the third of five samples discards the run.
    start     = 1'b1;
    n_samples = 16'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b0;
      tick();
      valid_in = 1'b1;
      r_exact  = $urandom();
      r_approx = $urandom();
      tick();
    end
    valid_in = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    valid_in = 1'b0;
    q_ex.delete();
    q_ap.delete();
    check_ctrl("midrst", 1'b0, 1'b0);
    check_stats("midrst");
    for (int i = 0; i < 4; i++) begin
      tick();
      check_ctrl("midrst_quiet", 1'b0, 1'b0);
    end
    repeat (5) add_rand();
    run("postrst", 1, 1'b0);

    // Saturation of the 33-bit sum: two max diffs fit, three do not.
    repeat (2) add_pair(32'hFFFF_FFFF, 32'h0);
    run("sat2", 0, 1'b0);
    repeat (3) add_pair(32'h0, 32'hFFFF_FFFF);
    run("sat3", 1, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(1, 12)) add_rand();
      run("rand", 2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
